// File: rtl/if2_fetch_queue_if.sv
// Instruction-cache read channel between the second fetch stage and the I-cache.
// The fetch stage is the master: it holds req/addr until the cache pulses ack with data.
interface if2_fetch_queue_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [63:0] data;

    modport master (output req, output addr, input ack, input data);
    modport slave  (input req, input addr, output ack, output data);
endinterface

// File: rtl/if2_fetch_queue.sv
// Second fetch stage: one aligned I-cache read per fetch packet, split into up to
// two instruction slots and pushed into a small circular queue feeding decode.
module if2_fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        cpu_clk_i,
    input  logic        cpu_rst_i,
    input  logic        flush_i,
    input  logic        if2_vld_i,
    input  logic [31:0] if2_sip_vpc_i,
    input  logic        if2_excp_vld_i,
    input  logic [3:0]  if2_excp_code_i,
    input  logic [1:0]  if2_btype_i,
    input  logic [1:0]  if2_bm_pred_i,
    input  logic        if2_btb_hit_i,
    input  logic        if2_btb_index_i,
    input  logic        if2_btb_way_i,
    input  logic [31:0] if2_btb_target_i,
    output logic        if2_busy_o,
    if2_fetch_queue_if.master icache,
    output logic        ins_vld_o,
    input  logic        ins_rdy_i,
    output logic [31:0] ins_o,
    output logic [31:0] ins_pc_o,
    output logic        ins_excp_vld_o,
    output logic [3:0]  ins_excp_code_o,
    output logic        ins_btb_hit_o,
    output logic [1:0]  ins_btype_o,
    output logic [1:0]  ins_bm_pred_o,
    output logic        ins_btb_way_o,
    output logic [31:0] ins_target_o
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        excp_vld;
        logic [3:0]  excp_code;
        logic        btb_hit;
        logic [1:0]  btype;
        logic [1:0]  bm_pred;
        logic        btb_way;
        logic [31:0] target;
    } entry_t;

    entry_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt1;
    logic [AW:0]   count, free;
    logic [1:0]    state;

    logic [31:2] pkt_pc;
    logic        pkt_hit, pkt_idx, pkt_way;
    logic [1:0]  pkt_btype, pkt_bm;
    logic [31:0] pkt_tgt;

    logic        accept, pop, ack_push;
    logic        slot0_push, slot1_push, slot0_taken;
    logic [1:0]  push_n;
    entry_t      slot0_e, slot1_e, push_a, push_b;

    // Credit is taken from the registered count only, so a same-cycle pop never admits a packet.
    assign free        = (AW+1)'(DEPTH) - count;
    assign if2_busy_o  = (state != IDLE) || (free < (AW+1)'(2));
    assign ins_vld_o   = (count != '0);
    assign pop         = ins_vld_o & ins_rdy_i;
    assign wr_ptr_nxt1 = wr_ptr + AW'(1);

    assign accept   = (state == IDLE) & if2_vld_i & ~flush_i & (free >= (AW+1)'(2));
    assign ack_push = (state == WAIT) & icache.ack & ~flush_i;

    always_comb begin
        slot0_push  = ~pkt_pc[2];
        slot0_taken = pkt_hit & ~pkt_idx & ((pkt_btype != 2'b00) | pkt_bm[1]);
        slot1_push  = ~(slot0_push & slot0_taken);

        slot0_e           = '0;
        slot0_e.ins       = icache.data[31:0];
        slot0_e.pc        = {pkt_pc[31:3], 3'b000};
        slot0_e.btb_hit   = pkt_hit & ~pkt_idx;
        slot1_e           = '0;
        slot1_e.ins       = icache.data[63:32];
        slot1_e.pc        = {pkt_pc[31:3], 3'b100};
        slot1_e.btb_hit   = pkt_hit & pkt_idx;
        if (slot0_e.btb_hit) begin
            slot0_e.btype   = pkt_btype;
            slot0_e.bm_pred = pkt_bm;
            slot0_e.btb_way = pkt_way;
            slot0_e.target  = pkt_tgt;
        end
        if (slot1_e.btb_hit) begin
            slot1_e.btype   = pkt_btype;
            slot1_e.bm_pred = pkt_bm;
            slot1_e.btb_way = pkt_way;
            slot1_e.target  = pkt_tgt;
        end

        push_n = 2'd0;
        push_a = '0;
        push_b = '0;
        if (accept && if2_excp_vld_i) begin
            push_n           = 2'd1;
            push_a.pc        = if2_sip_vpc_i;
            push_a.excp_vld  = 1'b1;
            push_a.excp_code = if2_excp_code_i;
        end else if (ack_push) begin
            if (slot0_push && slot1_push) begin
                push_n = 2'd2;
                push_a = slot0_e;
                push_b = slot1_e;
            end else begin
                push_n = 2'd1;
                push_a = slot0_push ? slot0_e : slot1_e;
            end
        end
    end

    // Queue storage and pointers; flush wins over any same-cycle push or pop.
    always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
        if (cpu_rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_n != 2'd0) mem[wr_ptr]      <= push_a;
            if (push_n == 2'd2) mem[wr_ptr_nxt1] <= push_b;
            wr_ptr <= wr_ptr + AW'(push_n);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW+1)'(push_n) - (AW+1)'(pop);
        end
    end

    // Request FSM; DRAIN keeps req up so the outstanding read completes and is thrown away.
    always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
        if (cpu_rst_i) begin
            state       <= IDLE;
            icache.req  <= 1'b0;
            icache.addr <= '0;
            pkt_pc      <= '0;
            pkt_hit     <= 1'b0;
            pkt_idx     <= 1'b0;
            pkt_way     <= 1'b0;
            pkt_btype   <= '0;
            pkt_bm      <= '0;
            pkt_tgt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && !if2_excp_vld_i) begin
                        state       <= WAIT;
                        icache.req  <= 1'b1;
                        icache.addr <= {if2_sip_vpc_i[31:3], 3'b000};
                        pkt_pc      <= if2_sip_vpc_i[31:2];
                        pkt_hit     <= if2_btb_hit_i;
                        pkt_idx     <= if2_btb_index_i;
                        pkt_way     <= if2_btb_way_i;
                        pkt_btype   <= if2_btype_i;
                        pkt_bm      <= if2_bm_pred_i;
                        pkt_tgt     <= if2_btb_target_i;
                    end
                end
                WAIT: begin
                    if (icache.ack) begin
                        state      <= IDLE;
                        icache.req <= 1'b0;
                    end else if (flush_i) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (icache.ack && !flush_i) begin
                        state      <= IDLE;
                        icache.req <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    icache.req <= 1'b0;
                end
            endcase
        end
    end

    assign ins_o           = mem[rd_ptr].ins;
    assign ins_pc_o        = mem[rd_ptr].pc;
    assign ins_excp_vld_o  = mem[rd_ptr].excp_vld;
    assign ins_excp_code_o = mem[rd_ptr].excp_code;
    assign ins_btb_hit_o   = mem[rd_ptr].btb_hit;
    assign ins_btype_o     = mem[rd_ptr].btype;
    assign ins_bm_pred_o   = mem[rd_ptr].bm_pred;
    assign ins_btb_way_o   = mem[rd_ptr].btb_way;
    assign ins_target_o    = mem[rd_ptr].target;

endmodule

// File: tb/tb_if2_fetch_queue.sv
// Directed bench for if2_fetch_queue: a vector table of fetch packets with their
// expected queue entries, plus hand-written back-pressure, flush and reset sequences.
module tb_if2_fetch_queue;

    logic        cpu_clk_i = 1'b0;
    logic        cpu_rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        if2_vld_i = 1'b0;
    logic [31:0] if2_sip_vpc_i = '0;
    logic        if2_excp_vld_i = 1'b0;
    logic [3:0]  if2_excp_code_i = '0;
    logic [1:0]  if2_btype_i = '0;
    logic [1:0]  if2_bm_pred_i = '0;
    logic        if2_btb_hit_i = 1'b0;
    logic        if2_btb_index_i = 1'b0;
    logic        if2_btb_way_i = 1'b0;
    logic [31:0] if2_btb_target_i = '0;
    logic        if2_busy_o;
    logic        ins_vld_o;
    logic        ins_rdy_i = 1'b0;
    logic [31:0] ins_o, ins_pc_o, ins_target_o;
    logic        ins_excp_vld_o, ins_btb_hit_o, ins_btb_way_o;
    logic [3:0]  ins_excp_code_o;
    logic [1:0]  ins_btype_o, ins_bm_pred_o;

    int n_checks = 0;
    int n_fail   = 0;

    if2_fetch_queue_if icache ();

    if2_fetch_queue #(.DEPTH(4)) dut (
        .cpu_clk_i        (cpu_clk_i),
        .cpu_rst_i        (cpu_rst_i),
        .flush_i          (flush_i),
        .if2_vld_i        (if2_vld_i),
        .if2_sip_vpc_i    (if2_sip_vpc_i),
        .if2_excp_vld_i   (if2_excp_vld_i),
        .if2_excp_code_i  (if2_excp_code_i),
        .if2_btype_i      (if2_btype_i),
        .if2_bm_pred_i    (if2_bm_pred_i),
        .if2_btb_hit_i    (if2_btb_hit_i),
        .if2_btb_index_i  (if2_btb_index_i),
        .if2_btb_way_i    (if2_btb_way_i),
        .if2_btb_target_i (if2_btb_target_i),
        .if2_busy_o       (if2_busy_o),
        .icache           (icache.master),
        .ins_vld_o        (ins_vld_o),
        .ins_rdy_i        (ins_rdy_i),
        .ins_o            (ins_o),
        .ins_pc_o         (ins_pc_o),
        .ins_excp_vld_o   (ins_excp_vld_o),
        .ins_excp_code_o  (ins_excp_code_o),
        .ins_btb_hit_o    (ins_btb_hit_o),
        .ins_btype_o      (ins_btype_o),
        .ins_bm_pred_o    (ins_bm_pred_o),
        .ins_btb_way_o    (ins_btb_way_o),
        .ins_target_o     (ins_target_o)
    );

    always #5 cpu_clk_i = ~cpu_clk_i;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct {
        logic [31:0] pc;
        logic        excp;
        logic [3:0]  code;
        logic        hit;
        logic        idx;
        logic [1:0]  btype;
        logic [1:0]  bm;
        logic [31:0] tgt;
        logic [63:0] data;
        int          delay;
        int          n;
        logic [31:0] e_ins0, e_pc0, e_ins1, e_pc1;
        logic        e_hit0, e_hit1;
    } vec_t;

    function automatic vec_t mkv(input logic [31:0] pc, input logic excp, input logic [3:0] code,
                                 input logic hit, input logic idx, input logic [1:0] btype,
                                 input logic [1:0] bm, input logic [63:0] data, input int delay,
                                 input int n, input logic [31:0] ins0, input logic [31:0] pc0,
                                 input logic hit0, input logic [31:0] ins1, input logic [31:0] pc1,
                                 input logic hit1);
        vec_t v;
        v.pc = pc; v.excp = excp; v.code = code; v.hit = hit; v.idx = idx;
        v.btype = btype; v.bm = bm; v.tgt = 32'h8000_0000 ^ pc; v.data = data;
        v.delay = delay; v.n = n;
        v.e_ins0 = ins0; v.e_pc0 = pc0; v.e_hit0 = hit0;
        v.e_ins1 = ins1; v.e_pc1 = pc1; v.e_hit1 = hit1;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; drives the packet, then services the cache read with a one-cycle ack.
    task automatic applyStimulus(input vec_t v);
        checkOutput("busy_before_accept", 64'(if2_busy_o), 64'd0);
        if2_vld_i        = 1'b1;
        if2_sip_vpc_i    = v.pc;
        if2_excp_vld_i   = v.excp;
        if2_excp_code_i  = v.code;
        if2_btb_hit_i    = v.hit;
        if2_btb_index_i  = v.idx;
        if2_btb_way_i    = v.hit;
        if2_btype_i      = v.btype;
        if2_bm_pred_i    = v.bm;
        if2_btb_target_i = v.tgt;
        @(negedge cpu_clk_i);
        if2_vld_i = 1'b0;
        if (v.excp) begin
            checkOutput("excp_no_req", 64'(icache.req), 64'd0);
        end else begin
            checkOutput("req_after_accept", 64'(icache.req), 64'd1);
            checkOutput("icache_addr", 64'(icache.addr), 64'({v.pc[31:3], 3'b000}));
            repeat (v.delay) @(negedge cpu_clk_i);
            icache.ack  = 1'b1;
            icache.data = v.data;
            @(negedge cpu_clk_i);
            icache.ack  = 1'b0;
            icache.data = '0;
            checkOutput("req_dropped", 64'(icache.req), 64'd0);
        end
    endtask

    // Called at a negedge; checks the head entry and pops it.
    task automatic popCheck(input logic [31:0] e_ins, input logic [31:0] e_pc, input logic e_hit,
                            input vec_t v);
        checkOutput("head_valid", 64'(ins_vld_o), 64'd1);
        checkOutput("head_ins", 64'(ins_o), 64'(e_ins));
        checkOutput("head_pc", 64'(ins_pc_o), 64'(e_pc));
        checkOutput("head_btb_hit", 64'(ins_btb_hit_o), 64'(e_hit));
        checkOutput("head_target", 64'(ins_target_o), 64'(e_hit ? v.tgt : 32'd0));
        checkOutput("head_pred", 64'({ins_btype_o, ins_bm_pred_o, ins_btb_way_o}),
                    64'(e_hit ? {v.btype, v.bm, 1'b1} : 5'd0));
        checkOutput("head_excp", 64'({ins_excp_vld_o, ins_excp_code_o}),
                    64'(v.excp ? {1'b1, v.code} : 5'd0));
        ins_rdy_i = 1'b1;
        @(negedge cpu_clk_i);
        ins_rdy_i = 1'b0;
    endtask

    vec_t vecs[8];
    vec_t va, vb, vc, vf;

    initial begin
        icache.ack  = 1'b0;
        icache.data = '0;

        vecs[0] = mkv(32'h100, 0, 4'h0, 0, 0, 2'b00, 2'b00, 64'h11111111_22222222, 2, 2,
                      32'h22222222, 32'h100, 0, 32'h11111111, 32'h104, 0);
        vecs[1] = mkv(32'h204, 0, 4'h0, 0, 0, 2'b00, 2'b00, 64'hAAAA0000_BBBB0000, 0, 1,
                      32'hAAAA0000, 32'h204, 0, 32'h0, 32'h0, 0);
        vecs[2] = mkv(32'h300, 0, 4'h0, 1, 0, 2'b00, 2'b10, 64'h33333333_44444444, 1, 1,
                      32'h44444444, 32'h300, 1, 32'h0, 32'h0, 0);
        vecs[3] = mkv(32'h300, 0, 4'h0, 1, 0, 2'b00, 2'b01, 64'h33333333_44444444, 0, 2,
                      32'h44444444, 32'h300, 1, 32'h33333333, 32'h304, 0);
        vecs[4] = mkv(32'h400, 0, 4'h0, 1, 1, 2'b01, 2'b00, 64'h44440000_40400000, 1, 2,
                      32'h40400000, 32'h400, 0, 32'h44440000, 32'h404, 1);
        vecs[5] = mkv(32'h504, 0, 4'h0, 1, 0, 2'b01, 2'b00, 64'h55555555_50505050, 0, 1,
                      32'h55555555, 32'h504, 0, 32'h0, 32'h0, 0);
        vecs[6] = mkv(32'h608, 1, 4'h1, 0, 0, 2'b00, 2'b00, 64'h0, 0, 1,
                      32'h0, 32'h608, 0, 32'h0, 32'h0, 0);
        vecs[7] = mkv(32'h700, 0, 4'h0, 1, 0, 2'b10, 2'b00, 64'h77777777_66666666, 2, 1,
                      32'h66666666, 32'h700, 1, 32'h0, 32'h0, 0);

        // Reset state
        repeat (3) @(negedge cpu_clk_i);
        cpu_rst_i = 1'b0;
        @(negedge cpu_clk_i);
        checkOutput("rst_req", 64'(icache.req), 64'd0);
        checkOutput("rst_vld", 64'(ins_vld_o), 64'd0);
        checkOutput("rst_busy", 64'(if2_busy_o), 64'd0);
        checkOutput("rst_data", 64'({ins_o, ins_pc_o}), 64'd0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            popCheck(vecs[i].e_ins0, vecs[i].e_pc0, vecs[i].e_hit0, vecs[i]);
            if (vecs[i].n == 2) popCheck(vecs[i].e_ins1, vecs[i].e_pc1, vecs[i].e_hit1, vecs[i]);
            checkOutput("queue_empty", 64'(ins_vld_o), 64'd0);
        end

        // Back-pressure: two packets fill DEPTH=4, the third waits for two pops
        va = vecs[0];
        vb = mkv(32'h108, 0, 4'h0, 0, 0, 2'b00, 2'b00, 64'hB1B1B1B1_B0B0B0B0, 0, 2,
                 32'hB0B0B0B0, 32'h108, 0, 32'hB1B1B1B1, 32'h10C, 0);
        vc = mkv(32'h110, 0, 4'h0, 0, 0, 2'b00, 2'b00, 64'hC1C1C1C1_C0C0C0C0, 0, 2,
                 32'hC0C0C0C0, 32'h110, 0, 32'hC1C1C1C1, 32'h114, 0);
        applyStimulus(va);
        applyStimulus(vb);
        checkOutput("full_busy", 64'(if2_busy_o), 64'd1);
        if2_vld_i     = 1'b1;
        if2_sip_vpc_i = vc.pc;
        if2_btb_hit_i = 1'b0;
        if2_excp_vld_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge cpu_clk_i);
            checkOutput("full_no_req", 64'(icache.req), 64'd0);
            checkOutput("full_busy_hold", 64'(if2_busy_o), 64'd1);
        end
        popCheck(va.e_ins0, va.e_pc0, 1'b0, va);
        checkOutput("one_pop_busy", 64'(if2_busy_o), 64'd1);
        checkOutput("one_pop_no_req", 64'(icache.req), 64'd0);
        popCheck(va.e_ins1, va.e_pc1, 1'b0, va);
        checkOutput("busy_released", 64'(if2_busy_o), 64'd0);
        @(negedge cpu_clk_i);
        if2_vld_i = 1'b0;
        checkOutput("third_req", 64'(icache.req), 64'd1);
        checkOutput("third_addr", 64'(icache.addr), 64'h110);
        icache.ack  = 1'b1;
        icache.data = vc.data;
        @(negedge cpu_clk_i);
        icache.ack  = 1'b0;
        icache.data = '0;
        popCheck(vb.e_ins0, vb.e_pc0, 1'b0, vb);
        popCheck(vb.e_ins1, vb.e_pc1, 1'b0, vb);
        popCheck(vc.e_ins0, vc.e_pc0, 1'b0, vc);
        popCheck(vc.e_ins1, vc.e_pc1, 1'b0, vc);
        checkOutput("bp_empty", 64'(ins_vld_o), 64'd0);

        // Flush one cycle before ack, with an entry already queued
        applyStimulus(vecs[6]);
        checkOutput("pre_flush_vld", 64'(ins_vld_o), 64'd1);
        vf = vecs[0];
        vf.pc = 32'h800;
        if2_excp_vld_i = 1'b0;
        checkOutput("flush_pkt_busy", 64'(if2_busy_o), 64'd0);
        if2_vld_i     = 1'b1;
        if2_sip_vpc_i = vf.pc;
        @(negedge cpu_clk_i);
        if2_vld_i = 1'b0;
        flush_i   = 1'b1;
        @(negedge cpu_clk_i);
        flush_i = 1'b0;
        checkOutput("flush_cleared", 64'(ins_vld_o), 64'd0);
        checkOutput("drain_busy", 64'(if2_busy_o), 64'd1);
        checkOutput("drain_req", 64'(icache.req), 64'd1);
        icache.ack  = 1'b1;
        icache.data = 64'hDEADDEAD_BEEFBEEF;
        @(negedge cpu_clk_i);
        icache.ack = 1'b0;
        checkOutput("drain_req_drop", 64'(icache.req), 64'd0);
        checkOutput("drain_idle", 64'(if2_busy_o), 64'd0);
        checkOutput("drain_discard", 64'(ins_vld_o), 64'd0);

        // Flush coincident with ack
        if2_vld_i     = 1'b1;
        if2_sip_vpc_i = 32'h900;
        @(negedge cpu_clk_i);
        if2_vld_i = 1'b0;
        checkOutput("fa_req", 64'(icache.req), 64'd1);
        flush_i     = 1'b1;
        icache.ack  = 1'b1;
        icache.data = 64'h12345678_9ABCDEF0;
        @(negedge cpu_clk_i);
        flush_i    = 1'b0;
        icache.ack = 1'b0;
        checkOutput("fa_req_drop", 64'(icache.req), 64'd0);
        checkOutput("fa_idle", 64'(if2_busy_o), 64'd0);
        checkOutput("fa_no_push", 64'(ins_vld_o), 64'd0);

        // Reset in the middle of a request
        if2_vld_i     = 1'b1;
        if2_sip_vpc_i = 32'hA00;
        @(negedge cpu_clk_i);
        if2_vld_i = 1'b0;
        checkOutput("mr_req", 64'(icache.req), 64'd1);
        #1 cpu_rst_i = 1'b1;
        #1;
        checkOutput("mr_req_clear", 64'(icache.req), 64'd0);
        checkOutput("mr_busy_clear", 64'(if2_busy_o), 64'd0);
        @(negedge cpu_clk_i);
        cpu_rst_i = 1'b0;
        @(negedge cpu_clk_i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
